// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, reset PC default and
// the prefetcher's RUN/FLUSH state encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        PF_RUN   = 1'b0,
        PF_FLUSH = 1'b1
    } pf_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/pf_fifo.sv
// Synchronous FIFO holding prefetched {pc, instr} pairs; head is read
// straight from the storage registers, and clear empties it in one cycle.
module pf_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push into a full FIFO is allowed when the head leaves the same cycle.
    assign push_en = push && (!full || pop);
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: in-order fetch into a DEPTH-entry buffer with
// redirect/flush. Define PREFETCH_PERF_EN to add the stall_cnt output.
module instr_prefetch
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    pf_state_e         state, state_n;
    logic [CW-1:0]     entries;
    logic [CW-1:0]     outstanding, outstanding_n;
    logic [CW-1:0]     discard, discard_n;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_n;
    logic [XLEN-1:0]   rsp_pc, rsp_pc_n;
    logic [CW:0]       in_flight;
    logic              started;
    logic              accept;
    logic              rsp_take;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] head;

    // started keeps req_valid low until the first edge after reset release.
    assign in_flight = {1'b0, entries} + {1'b0, outstanding};
    assign req_valid = started && (state == PF_RUN) && (in_flight < DEPTH_W);
    assign req_addr  = fetch_pc;
    assign accept    = req_valid && req_ready;
    assign rsp_take  = rsp_valid && (outstanding != '0);

    assign out_valid = (entries != '0);
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = rsp_take && (state == PF_RUN) && !redirect;
    assign out_pc    = head[2*XLEN-1:XLEN];
    assign out_instr = head[XLEN-1:0];

    pf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data ({rsp_pc, rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (entries)
    );

    always_comb begin
        state_n       = state;
        discard_n     = discard;
        fetch_pc_n    = fetch_pc;
        rsp_pc_n      = rsp_pc;
        outstanding_n = outstanding;

        case ({accept, rsp_take})
            2'b10:   outstanding_n = outstanding + 1'b1;
            2'b01:   outstanding_n = outstanding - 1'b1;
            default: outstanding_n = outstanding;
        endcase

        if (accept) begin
            fetch_pc_n = fetch_pc + 32'd4;
        end

        // Responses return in order, so rsp_pc tracks the address of the
        // next kept response; after a redirect everything in flight is stale.
        if (redirect) begin
            fetch_pc_n = word_align(redirect_pc);
            rsp_pc_n   = word_align(redirect_pc);
            discard_n  = outstanding_n;
            state_n    = (outstanding_n != '0) ? PF_FLUSH : PF_RUN;
        end else if (state == PF_RUN) begin
            if (push) begin
                rsp_pc_n = rsp_pc + 32'd4;
            end
        end else if (rsp_take) begin
            discard_n = discard - 1'b1;
            if (discard == CW'(1)) begin
                state_n = PF_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PF_RUN;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            started     <= 1'b0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            fetch_pc    <= fetch_pc_n;
            rsp_pc      <= rsp_pc_n;
            started     <= 1'b1;
        end
    end

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_ready && !out_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a fixed-latency in-order memory
// model; instruction data returned is address + 32'h1000_0000.
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef PREFETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    int unsigned n_edges;
    int unsigned lat;
    int unsigned n_accept;
    int          n_checks;
    int          n_errors;

    always #5 clk = ~clk;

    instr_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef PREFETCH_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, note accept/pop, then advance past the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        logic        rsp_now;
        rsp_now   = (mq.size() > 0) && (mq[0].due <= n_edges + 1);
        rsp_valid = rsp_now;
        rsp_data  = rsp_now ? (mq[0].addr + 32'h1000_0000) : 32'h0;
        acc       = req_valid && req_ready;
        acc_addr  = req_addr;
        if (out_valid && out_ready && !redirect) begin
            got_pc.push_back(out_pc);
            got_instr.push_back(out_instr);
        end
        @(posedge clk);
        n_edges++;
        #1;
        if (rsp_now) void'(mq.pop_front());
        if (acc) begin
            mq.push_back('{addr: acc_addr, due: n_edges + lat});
            n_accept++;
        end
        rsp_valid = 1'b0;
    endtask

    // Leaves reset asserted; memory model is reset alongside.
    task automatic do_reset();
        reset       = 1'b1;
        req_ready   = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        rsp_valid   = 1'b0;
        rsp_data    = 32'h0;
        lat         = 1;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        got_pc.delete();
        got_instr.delete();
        n_accept = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_edges  = 0;
        n_accept = 0;

        // Reset values and first request timing
        do_reset();
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        reset = 1'b0;
        #1;
        check("req_valid_before_first_edge", req_valid, 1'b0);
        req_ready = 1'b1;
        out_ready = 1'b1;
        tick();
        check("req_valid_after_first_edge", req_valid, 1'b1);
        check("first_req_addr", req_addr, 32'h0);

        // Streaming: one instruction per cycle after startup
        repeat (11) tick();
        check("stream_pop_count", got_pc.size(), 32'd9);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_pc_%0d", i), got_pc[i], 32'(4 * i));
        end
        check("stream_instr_0", got_instr[0], 32'h1000_0000);
        check("stream_instr_3", got_instr[3], 32'h1000_000C);

        // Decode stalled: buffer fills to DEPTH and fetch stops
        do_reset();
        check("rst2_out_valid", out_valid, 1'b0);
        reset     = 1'b0;
        req_ready = 1'b1;
        out_ready = 1'b0;
        repeat (20) tick();
        check("stall_accepts", n_accept, 32'd4);
        check("stall_req_valid", req_valid, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_mem_pending", mq.size(), 32'd0);
        check("stall_head_pc", out_pc, 32'h0);
        check("stall_head_instr", out_instr, 32'h1000_0000);
        out_ready = 1'b1;
        repeat (8) tick();
        check("release_pc_0", got_pc[0], 32'h0);
        check("release_pc_1", got_pc[1], 32'h4);
        check("release_pc_2", got_pc[2], 32'h8);
        check("release_pc_3", got_pc[3], 32'hC);
        check("release_pc_4", got_pc[4], 32'h10);

        // Redirect with three requests in flight on a 3-cycle memory
        do_reset();
        reset     = 1'b0;
        lat       = 3;
        req_ready = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("flush_pending", mq.size(), 32'd3);
        check("flush_req_valid", req_valid, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        tick();
        check("flush_req_valid_hold", req_valid, 1'b0);
        for (int i = 0; i < 40 && got_pc.size() < 2; i++) tick();
        check("flush_pops_seen", got_pc.size() >= 2, 1'b1);
        check("flush_first_pc", got_pc[0], 32'h0000_0100);
        check("flush_second_pc", got_pc[1], 32'h0000_0104);
        check("flush_first_instr", got_instr[0], 32'h1000_0100);

        // Redirect in the same cycle as a pop and a response
        do_reset();
        reset     = 1'b0;
        req_ready = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        check("pre_redirect_pops", got_pc.size(), 32'd3);
        check("pre_redirect_pc", got_pc[2], 32'h8);
        check("redirect_cycle_rsp_due", (mq.size() > 0) && (mq[0].due == n_edges + 1), 1'b1);
        check("redirect_cycle_out_valid", out_valid, 1'b1);
        got_pc.delete();
        got_instr.delete();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        check("post_redirect_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 40 && got_pc.size() < 2; i++) tick();
        check("redir_pops_seen", got_pc.size() >= 2, 1'b1);
        check("redir_first_pc", got_pc[0], 32'h0000_0200);
        check("redir_second_pc", got_pc[1], 32'h0000_0204);

        // Fetch PC wrap at the top of the address space
        do_reset();
        reset = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect  = 1'b0;
        check("wrap_req_addr", req_addr, 32'hFFFF_FFF8);
        req_ready = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && got_pc.size() < 3; i++) tick();
        check("wrap_pc_0", got_pc[0], 32'hFFFF_FFF8);
        check("wrap_pc_1", got_pc[1], 32'hFFFF_FFFC);
        check("wrap_pc_2", got_pc[2], 32'h0000_0000);
        check("wrap_instr_2", got_instr[2], 32'h1000_0000);

`ifdef PREFETCH_PERF_EN
        // Starved decode: stall counter advances once per cycle
        do_reset();
        check("rst_stall_cnt", stall_cnt, 32'h0);
        reset     = 1'b0;
        req_ready = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("stall_cnt_10", stall_cnt, 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port req_ready  input  1  memory accepts request.
REQ-007 SHALL have port req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port rsp_valid  input  1  instruction word returned, in request order, one per accepted request, latency >= 1.
REQ-009 SHALL have port rsp_data  input  32  returned instruction.
REQ-010 SHALL have port out_valid  output  1  buffered instruction available to decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes head entry.
REQ-012 SHALL have port out_pc  output  32  PC of head entry.
REQ-013 SHALL have port out_instr  output  32  head instruction.
REQ-014 SHALL have port redirect  input  1  branch/jal/jalr taken; flush.
REQ-015 SHALL have port redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0.

Function
REQ-016 SHALL issue a request whenever state is RUN and (entries + outstanding) < DEPTH; handshake completes on req_valid && req_ready.
REQ-017 SHALL hold req_addr and req_valid stable until accepted unless redirect occurs.
REQ-018 SHALL advance fetch PC by 4 per accepted request, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 SHALL push {pc, rsp_data} on each non-discarded rsp_valid; the pc pushed equals that request's req_addr.
REQ-020 SHALL pop head on out_valid && out_ready; out_valid = (entries != 0); head outputs registered, zero added latency from buffer.
REQ-021 SHALL support simultaneous push and pop at full or empty without loss; minimum rsp-to-out_valid latency 1 cycle.
REQ-022 SHALL track outstanding count (0..DEPTH), +1 on accept, -1 on rsp_valid, both same cycle -> unchanged.
REQ-023 SHALL have FSM states RUN and FLUSH; on redirect: clear buffer, fetch PC := redirect_pc, discard := outstanding after this cycle's updates; go FLUSH if discard != 0 else stay RUN.
REQ-024 SHALL in FLUSH issue no requests, drop each rsp_valid decrementing discard, return to RUN when discard reaches 0.
REQ-025 SHALL give redirect priority over same-cycle pop, push and accept; an accept in the redirect cycle counts as discardable.
REQ-026 SHALL handle redirect during FLUSH by replacing fetch PC, keeping remaining discard count.
REQ-027 SHALL deassert out_valid the cycle after redirect.

Reset
REQ-028 SHALL on reset: fetch PC = RESET_PC, state RUN, entries 0, outstanding 0, discard 0, req_valid 0, out_valid 0, out_pc 0, out_instr 0.
REQ-029 SHALL drop any response arriving during reset; memory is reset concurrently.
REQ-030 SHALL assert req_valid no earlier than first rising edge after reset deassertion.

Configuration
REQ-031 SHALL, with PREFETCH_PERF_EN defined, add output stall_cnt 32 bits counting cycles with out_ready=1 and out_valid=0, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-032 SHALL, without PREFETCH_PERF_EN, have no stall_cnt port and no counter logic.

Structure
REQ-033 SHALL take XLEN (32), RESET_PC default and the RUN/FLUSH state encoding from shared package riscv_pkg.
REQ-034 SHALL implement the buffer as sub-module pf_fifo (synchronous FIFO, DEPTH entries of 64 bits, count output).

Verification
REQ-035 SHALL cover: reset, req_ready=1, 1-cycle memory, out_ready=1 -> out_pc 0,4,8,... one per cycle after 2-cycle startup.
REQ-036 SHALL cover: out_ready=0 for 20 cycles -> exactly 4 entries buffered, req_valid low, no rsp lost; release -> 0,4,8,12 in order.
REQ-037 SHALL cover: redirect to 32'h100 with 3 outstanding, 3-cycle memory -> 3 responses dropped, next out_pc 32'h100.
REQ-038 SHALL cover: redirect same cycle as pop and rsp_valid -> out_valid 0 next cycle, rsp discarded, next out_pc = redirect_pc.
REQ-039 SHALL cover: fetch PC 32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 SHALL cover: PREFETCH_PERF_EN, out_ready=1, req_ready=0 for 10 cycles -> stall_cnt = 10.
